// File: rtl/coco_spi_host.sv
// coco_spi_host: SPI mode-0 master for the CoCo FDC cartridge command port.
// One request becomes one ss-low frame; shadows address pointer and bus ownership.
module coco_spi_host #(
    parameter int CLK_DIV    = 4,
    parameter int GAP_CYCLES = 16,
    parameter int SS_SETUP   = 4
) (
    input  logic        clock_50,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [7:0]  rsp_rdata,
    output logic [15:0] shadow_addr,
    output logic        bus_owned,
    output logic        sclk,
    output logic        mosi,
    input  logic        miso,
    output logic        ss
);

    typedef enum logic [2:0] {
        IDLE, LEAD, SHIFT, GAP, TRAIL, DONE
    } state_t;

    localparam logic [2:0] OP_SETADDR = 3'd1;
    localparam logic [2:0] OP_WRITE   = 3'd2;
    localparam logic [2:0] OP_READ    = 3'd3;
    localparam logic [2:0] OP_ACQUIRE = 3'd4;
    localparam logic [2:0] OP_RELEASE = 3'd5;

    localparam logic [15:0] LEAD_LAST = 16'(SS_SETUP - 1);
    localparam logic [15:0] DIV_LAST  = 16'(CLK_DIV - 1);
    localparam logic [15:0] GAP_LAST  = 16'(GAP_CYCLES - 1);

    state_t      state;
    state_t      state_d;
    logic [15:0] cnt;
    logic [3:0]  edge_cnt;
    logic [1:0]  byte_idx;
    logic [2:0]  op_q;
    logic [15:0] addr_q;
    logic [7:0]  data_q;
    logic [7:0]  tx_sr;
    logic [7:0]  rx_sr;

    logic        req_legal;
    logic        lead_end;
    logic        half_tick;
    logic        byte_end;
    logic        last_byte;
    logic        gap_end;
    logic        trail_end;
    logic [7:0]  byte0;
    logic [7:0]  nxt_byte;
    logic        is_set;
    logic        is_wr;
    logic        is_rd;
    logic        is_acq;
    logic        is_rel;

    // Index of the final byte in the frame for a given op.
    function automatic logic [1:0] last_idx(input logic [2:0] op);
        logic [1:0] n;
        case (op)
            OP_SETADDR:        n = 2'd2;
            OP_WRITE, OP_READ: n = 2'd1;
            default:           n = 2'd0;
        endcase
        return n;
    endfunction

    // Byte idx of the command sequence; byte 0 is the opcode itself.
    function automatic logic [7:0] op_byte(
        input logic [2:0]  op,
        input logic [1:0]  idx,
        input logic [15:0] addr,
        input logic [7:0]  data
    );
        logic [7:0] b;
        b = 8'h00;
        if (idx == 2'd0) begin
            b = {5'd0, op};
        end else begin
            case (op)
                OP_SETADDR: b = (idx == 2'd1) ? addr[15:8] : addr[7:0];
                OP_WRITE:   b = data;
                default:    b = 8'h00;
            endcase
        end
        return b;
    endfunction

    assign req_legal = (req_op >= OP_SETADDR) && (req_op <= OP_RELEASE);
    assign req_ready = (state == IDLE);
    assign byte0     = {5'd0, req_op};
    assign nxt_byte  = op_byte(op_q, byte_idx + 2'd1, addr_q, data_q);

    assign lead_end  = (state == LEAD) && (cnt == LEAD_LAST);
    assign half_tick = (state == SHIFT) && (cnt == DIV_LAST);
    assign byte_end  = half_tick && sclk && (edge_cnt == 4'd15);
    assign last_byte = (byte_idx == last_idx(op_q));
    assign gap_end   = (state == GAP) && (cnt == GAP_LAST);
    assign trail_end = (state == TRAIL) && (cnt == LEAD_LAST);

    assign is_set = (op_q == OP_SETADDR);
    assign is_wr  = (op_q == OP_WRITE);
    assign is_rd  = (op_q == OP_READ);
    assign is_acq = (op_q == OP_ACQUIRE);
    assign is_rel = (op_q == OP_RELEASE);

    // State register.
    always_ff @(posedge clock_50 or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_d;
    end

    // Next-state sequencing through the frame phases.
    always_comb begin
        state_d = state;
        case (state)
            IDLE:  if (req_valid) state_d = req_legal ? LEAD : DONE;
            LEAD:  if (lead_end) state_d = SHIFT;
            SHIFT: if (byte_end) state_d = last_byte ? TRAIL : GAP;
            GAP:   if (gap_end) state_d = SHIFT;
            TRAIL: if (trail_end) state_d = DONE;
            DONE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Frame datapath: SPI pins, shift registers, counters and shadows.
    always_ff @(posedge clock_50 or negedge reset) begin
        if (!reset) begin
            cnt         <= '0;
            edge_cnt    <= '0;
            byte_idx    <= '0;
            op_q        <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            tx_sr       <= '0;
            rx_sr       <= '0;
            rsp_valid   <= 1'b0;
            rsp_err     <= 1'b0;
            rsp_rdata   <= '0;
            shadow_addr <= '0;
            bus_owned   <= 1'b0;
            sclk        <= 1'b0;
            mosi        <= 1'b0;
            ss          <= 1'b1;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        op_q     <= req_op;
                        addr_q   <= req_addr;
                        data_q   <= req_wdata;
                        byte_idx <= '0;
                        edge_cnt <= '0;
                        cnt      <= '0;
                        if (req_legal) begin
                            ss    <= 1'b0;
                            tx_sr <= byte0;
                            mosi  <= byte0[7];
                        end else begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end
                    end
                end
                LEAD: begin
                    cnt <= lead_end ? '0 : cnt + 16'd1;
                end
                SHIFT: begin
                    if (half_tick) begin
                        cnt      <= '0;
                        sclk     <= ~sclk;
                        edge_cnt <= edge_cnt + 4'd1;
                        if (!sclk) begin
                            rx_sr <= {rx_sr[6:0], miso};
                        end else if (byte_end) begin
                            sclk <= 1'b0;
                            if (!last_byte) begin
                                byte_idx <= byte_idx + 2'd1;
                                tx_sr    <= nxt_byte;
                                mosi     <= nxt_byte[7];
                            end
                        end else begin
                            mosi  <= tx_sr[6];
                            tx_sr <= {tx_sr[6:0], 1'b0};
                        end
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                GAP: begin
                    cnt <= gap_end ? '0 : cnt + 16'd1;
                end
                TRAIL: begin
                    cnt <= trail_end ? '0 : cnt + 16'd1;
                    if (trail_end) begin
                        ss        <= 1'b1;
                        mosi      <= 1'b0;
                        rsp_valid <= 1'b1;
                        if (is_rd) rsp_rdata <= rx_sr;
                        unique case (1'b1)
                            is_set:        shadow_addr <= addr_q;
                            is_wr, is_rd:  shadow_addr <= shadow_addr + 16'd1;
                            is_acq:        bus_owned <= 1'b1;
                            is_rel:        bus_owned <= 1'b0;
                            default: ;
                        endcase
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_coco_spi_host.sv
// tb_coco_spi_host: directed ops with scoreboarded responses and SPI frames.
// A slave model returns fixed MISO words for READ frames.
module tb_coco_spi_host;

    logic        clock_50;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [15:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid;
    logic        rsp_err;
    logic [7:0]  rsp_rdata;
    logic [15:0] shadow_addr;
    logic        bus_owned;
    logic        sclk;
    logic        mosi;
    logic        miso;
    logic        ss;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [15:0] slave;
        int          fnb;
        logic [23:0] fbytes;
        int          flow;
        logic        e_err;
        logic [15:0] e_sh;
        logic        e_own;
        logic [7:0]  e_rd;
    } vec_t;

    typedef struct {
        logic        err;
        logic [15:0] sh;
        logic        own;
        logic [7:0]  rd;
    } rsp_exp_t;

    typedef struct {
        bit          abort;
        int          nb;
        logic [23:0] bytes;
        int          low;
    } frm_exp_t;

    rsp_exp_t    rsp_q[$];
    frm_exp_t    frm_q[$];
    vec_t        vecs[13];
    int          checks;
    int          errors;
    int          rsp_cnt;
    int          sclk_rises;
    int          frame_cnt;
    int          fe_cnt;
    logic [15:0] slave_word;

    coco_spi_host dut (
        .clock_50    (clock_50),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_op      (req_op),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_err     (rsp_err),
        .rsp_rdata   (rsp_rdata),
        .shadow_addr (shadow_addr),
        .bus_owned   (bus_owned),
        .sclk        (sclk),
        .mosi        (mosi),
        .miso        (miso),
        .ss          (ss)
    );

    initial clock_50 = 1'b0;
    always #10 clock_50 = ~clock_50;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // SPI slave: counts SCK falling edges in the frame, shifts out slave_word MSB first.
    always @(negedge sclk or posedge ss) begin
        if (ss) fe_cnt <= 0;
        else    fe_cnt <= fe_cnt + 1;
    end

    always_comb begin
        miso = 1'b0;
        if (!ss && fe_cnt < 16) miso = slave_word[4'(15 - fe_cnt)];
    end

    // Response monitor: pops one expectation per rsp_valid pulse.
    always @(negedge clock_50) begin : rsp_mon
        rsp_exp_t e;
        if (reset && rsp_valid) begin
            rsp_cnt++;
            if (rsp_q.size() == 0) begin
                chk("unexpected_rsp", 32'd1, 32'd0);
            end else begin
                e = rsp_q.pop_front();
                chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                chk("shadow_addr", {16'd0, shadow_addr}, {16'd0, e.sh});
                chk("bus_owned", {31'd0, bus_owned}, {31'd0, e.own});
                chk("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, e.rd});
            end
        end
    end

    // Frame monitor: MOSI bits on SCK rises, ss-low length, compared at ss rise.
    logic        sclk_prev;
    logic        in_frame;
    int          low_cnt;
    int          nbits;
    logic [23:0] rx_bits;

    always @(negedge clock_50) begin : frm_mon
        frm_exp_t f;
        if (sclk === 1'b1 && sclk_prev === 1'b0) begin
            sclk_rises++;
            if (!ss) begin
                rx_bits = {rx_bits[22:0], mosi};
                nbits++;
            end
        end
        sclk_prev = sclk;
        if (ss === 1'b0) begin
            if (!in_frame) begin
                in_frame = 1'b1;
                low_cnt  = 0;
                nbits    = 0;
                rx_bits  = '0;
            end
            low_cnt++;
        end else if (in_frame) begin
            in_frame = 1'b0;
            frame_cnt++;
            if (frm_q.size() == 0) begin
                chk("unexpected_frame", 32'd1, 32'd0);
            end else begin
                f = frm_q.pop_front();
                if (!f.abort) begin
                    chk("frame_bits", nbits, f.nb * 8);
                    chk("frame_bytes", {8'd0, rx_bits}, {8'd0, f.bytes});
                    chk("ss_low_cycles", low_cnt, f.low);
                end
            end
        end
    end

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clock_50);
        while (!req_ready && n < 2000) begin
            @(negedge clock_50);
            n++;
        end
        chk("req_ready_wait", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input bit noise, output int lat);
        rsp_exp_t r;
        frm_exp_t f;
        int       start;
        r = '{v.e_err, v.e_sh, v.e_own, v.e_rd};
        rsp_q.push_back(r);
        if (v.fnb > 0) begin
            f = '{1'b0, v.fnb, v.fbytes, v.flow};
            frm_q.push_back(f);
        end
        slave_word = v.slave;
        wait_ready();
        req_valid = 1'b1;
        req_op    = v.op;
        req_addr  = v.addr;
        req_wdata = v.wdata;
        start     = rsp_cnt;
        @(posedge clock_50);
        #1;
        req_valid = 1'b0;
        req_op    = 3'd0;
        req_addr  = 16'h0;
        req_wdata = 8'h0;
        lat       = 0;
        if (noise) begin
            repeat (30) @(negedge clock_50);
            req_valid = 1'b1;
            req_op    = 3'd2;
            req_wdata = 8'hFF;
            repeat (50) @(negedge clock_50);
            req_valid = 1'b0;
            req_op    = 3'd0;
        end
        while (rsp_cnt == start && lat < 3000) begin
            @(negedge clock_50);
            lat++;
        end
        chk("rsp_arrived", {31'd0, rsp_cnt != start}, 32'd1);
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int       lat;
        int       sr0;
        int       fc0;
        frm_exp_t fa;
        checks     = 0;
        errors     = 0;
        rsp_cnt    = 0;
        sclk_rises = 0;
        frame_cnt  = 0;
        sclk_prev  = 1'b0;
        in_frame   = 1'b0;
        low_cnt    = 0;
        nbits      = 0;
        rx_bits    = '0;
        slave_word = '0;
        req_valid  = 1'b0;
        req_op     = 3'd0;
        req_addr   = 16'h0;
        req_wdata  = 8'h0;
        reset      = 1'b1;

        //          op    addr      wd     slave     nb bytes       low  err  shadow    own  rdata
        vecs[0]  = '{3'd1, 16'h12AB, 8'h00, 16'h0000, 3, 24'h0112AB, 232, 1'b0, 16'h12AB, 1'b0, 8'h00};
        vecs[1]  = '{3'd1, 16'h0040, 8'h00, 16'h0000, 3, 24'h010040, 232, 1'b0, 16'h0040, 1'b0, 8'h00};
        vecs[2]  = '{3'd2, 16'h0000, 8'h5A, 16'h0000, 2, 24'h00025A, 152, 1'b0, 16'h0041, 1'b0, 8'h00};
        vecs[3]  = '{3'd3, 16'h0000, 8'h00, 16'h00C3, 2, 24'h000300, 152, 1'b0, 16'h0042, 1'b0, 8'hC3};
        vecs[4]  = '{3'd1, 16'hFFFF, 8'h00, 16'h0000, 3, 24'h01FFFF, 232, 1'b0, 16'hFFFF, 1'b0, 8'hC3};
        vecs[5]  = '{3'd3, 16'h0000, 8'h00, 16'hFF5E, 2, 24'h000300, 152, 1'b0, 16'h0000, 1'b0, 8'h5E};
        vecs[6]  = '{3'd2, 16'h0000, 8'hA5, 16'h0000, 2, 24'h0002A5, 152, 1'b0, 16'h0001, 1'b0, 8'h5E};
        vecs[7]  = '{3'd4, 16'h0000, 8'h00, 16'h0000, 1, 24'h000004, 72,  1'b0, 16'h0001, 1'b1, 8'h5E};
        vecs[8]  = '{3'd7, 16'hBEEF, 8'h77, 16'h0000, 0, 24'h000000, 0,   1'b1, 16'h0001, 1'b1, 8'h5E};
        vecs[9]  = '{3'd5, 16'h0000, 8'h00, 16'h0000, 1, 24'h000005, 72,  1'b0, 16'h0001, 1'b0, 8'h5E};
        vecs[10] = '{3'd0, 16'h4444, 8'h00, 16'h0000, 0, 24'h000000, 0,   1'b1, 16'h0001, 1'b0, 8'h5E};
        vecs[11] = '{3'd1, 16'h1234, 8'h00, 16'h0000, 3, 24'h011234, 232, 1'b0, 16'h1234, 1'b0, 8'h5E};
        vecs[12] = '{3'd1, 16'h0003, 8'h00, 16'h0000, 3, 24'h010003, 232, 1'b0, 16'h0003, 1'b0, 8'h00};

        #3 reset = 1'b0;
        repeat (3) @(negedge clock_50);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
        chk("rst_shadow", {16'd0, shadow_addr}, 32'd0);
        chk("rst_bus_owned", {31'd0, bus_owned}, 32'd0);
        chk("rst_sclk", {31'd0, sclk}, 32'd0);
        chk("rst_mosi", {31'd0, mosi}, 32'd0);
        chk("rst_ss", {31'd0, ss}, 32'd1);
        reset = 1'b1;

        for (int i = 0; i < 12; i++) begin
            sr0 = sclk_rises;
            fc0 = frame_cnt;
            run_vec(vecs[i], i == 11, lat);
            if (vecs[i].e_err) begin
                chk("illegal_latency", {31'd0, lat <= 3}, 32'd1);
                chk("illegal_no_sck", sclk_rises, sr0);
                chk("illegal_no_ss", frame_cnt, fc0);
            end
        end

        fa = '{1'b1, 0, 24'h0, 0};
        frm_q.push_back(fa);
        slave_word = '0;
        wait_ready();
        req_valid = 1'b1;
        req_op    = 3'd1;
        req_addr  = 16'h7777;
        @(posedge clock_50);
        #1;
        req_valid = 1'b0;
        req_op    = 3'd0;
        req_addr  = 16'h0;
        repeat (110) @(negedge clock_50);
        chk("abort_mid_frame_ss", {31'd0, ss}, 32'd0);
        reset = 1'b0;
        #1;
        chk("abort_ss", {31'd0, ss}, 32'd1);
        chk("abort_sclk", {31'd0, sclk}, 32'd0);
        chk("abort_mosi", {31'd0, mosi}, 32'd0);
        chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("abort_shadow", {16'd0, shadow_addr}, 32'd0);
        chk("abort_bus_owned", {31'd0, bus_owned}, 32'd0);
        chk("abort_rsp_rdata", {24'd0, rsp_rdata}, 32'd0);
        repeat (3) @(negedge clock_50);
        reset = 1'b1;
        repeat (300) @(negedge clock_50);

        run_vec(vecs[12], 1'b0, lat);
        repeat (10) @(negedge clock_50);

        chk("rsp_q_empty", rsp_q.size(), 32'd0);
        chk("frm_q_empty", frm_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
